// File: rtl/core85_pkg.sv
// core85_pkg: shared state encoding, info-word field positions and bus status
// codes for the 8085-compatible core.
package core85_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_T5, S_T6, S_THLT
   } state_e;
   localparam int GO6 = 0;
   localparam int DAD = 1;
   localparam int HLT = 2;
   localparam int DIO = 3;
   localparam int CYL = 4;
   localparam int CYH = 7;
   localparam int RWL = 8;
   localparam int RWH = 11;
   localparam int CCC = 12;
   localparam logic [1:0] ST_FETCH = 2'b11;
   localparam logic [1:0] ST_READ  = 2'b10;
   localparam logic [1:0] ST_WRITE = 2'b01;
   localparam logic [1:0] ST_HALT  = 2'b00;
endpackage

// File: rtl/ctrlseq.sv
// ctrlseq: T-state / machine-cycle sequencer driving 8085 bus strobes and the
// datapath enables from the decoded instruction info word.
module ctrlseq
   import core85_pkg::*;
#(
   parameter int INSTSIZE = 13,
   parameter int INFO_CYC = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INSTSIZE-1:0] chk_inst,
   input  logic                ready,
   output logic                ale,
   output logic                rd_n,
   output logic                wr_n,
   output logic                iom,
   output logic [1:0]          s,
   output logic                enb_code,
   output logic                enb_data,
   output logic                enb_rreg,
   output logic                enb_wreg,
   output logic                pc_inc,
   output logic [INFO_CYC-1:0] mcyc,
   output logic [2:0]          tst,
   output logic                halted
);
   state_e              state_q, state_d;
   logic [INFO_CYC-1:0] mcyc_q, mcyc_d, cnt_q, rwf_q;
   logic                go6_q, hlt_q, wb_q, wb_d;
   logic                m1, wr, strobe, single;
   logic [1:0]          rw_idx;
   logic                unused_info;

   assign unused_info = ^{chk_inst[DIO], chk_inst[CCC]};
   assign m1     = mcyc_q == '0;
   assign rw_idx = 2'(mcyc_q - INFO_CYC'(1));
   // Only the first four extra cycles carry a write flag; later ones always read.
   assign wr     = !m1 && mcyc_q <= INFO_CYC'(4) && rwf_q[rw_idx];
   assign strobe = state_q == S_T2 || state_q == S_TW || state_q == S_T3;
   assign single = chk_inst[CYH:CYL] == '0 && !chk_inst[GO6] && !chk_inst[DAD] && !chk_inst[HLT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mcyc_q  <= '0;
         cnt_q   <= '0;
         rwf_q   <= '0;
         go6_q   <= 1'b0;
         hlt_q   <= 1'b0;
         wb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mcyc_q  <= mcyc_d;
         wb_q    <= wb_d;
         if (state_q == S_T4) begin
            cnt_q <= chk_inst[CYH:CYL];
            rwf_q <= chk_inst[RWH:RWL];
            go6_q <= chk_inst[GO6];
            hlt_q <= chk_inst[HLT];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mcyc_d  = mcyc_q;
      wb_d    = wb_q;
      case (state_q)
         S_IDLE: state_d = S_T1;
         S_T1: begin
            state_d = S_T2;
            wb_d    = m1 ? 1'b0 : wb_q;
         end
         S_T2, S_TW: state_d = ready ? S_T3 : S_TW;
         S_T3: begin
            state_d = m1 ? S_T4 : S_T1;
            if (!m1) begin
               mcyc_d = mcyc_q < cnt_q ? mcyc_q + INFO_CYC'(1) : '0;
               wb_d   = mcyc_q < cnt_q ? wb_q : !wr;
            end
         end
         // Info word is still live in T4, so use it directly rather than the latch.
         S_T4: begin
            state_d = chk_inst[GO6] ? S_T5 : chk_inst[HLT] ? S_THLT : S_T1;
            mcyc_d  = INFO_CYC'(!chk_inst[GO6] && !chk_inst[HLT] && chk_inst[CYH:CYL] != '0);
         end
         S_T5: state_d = S_T6;
         S_T6: begin
            state_d = hlt_q ? S_THLT : S_T1;
            mcyc_d  = INFO_CYC'(!hlt_q && cnt_q != '0);
         end
         S_THLT: state_d = S_THLT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ale      = state_q == S_T1;
      rd_n     = !(strobe && !wr);
      wr_n     = !(strobe && wr);
      iom      = 1'b0;
      s        = state_q == S_THLT ? ST_HALT : m1 ? ST_FETCH : wr ? ST_WRITE : ST_READ;
      enb_code = state_q == S_T3 && m1;
      pc_inc   = enb_code;
      enb_data = state_q == S_T3 && !m1 && !wr;
      enb_wreg = (state_q == S_T4 && single) || (state_q == S_T1 && m1 && wb_q);
      enb_rreg = enb_wreg || (strobe && wr);
      mcyc     = mcyc_q;
      halted   = state_q == S_THLT;
      tst      = state_q == S_T1 ? 3'd1 :
                 state_q == S_T2 || state_q == S_TW ? 3'd2 :
                 state_q == S_T3 ? 3'd3 :
                 state_q == S_T4 ? 3'd4 :
                 state_q == S_T5 ? 3'd5 :
                 state_q == S_T6 ? 3'd6 : 3'd0;
   end
endmodule
